// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG run-length coefficient expander.
//   state_t      : expander FSM state encoding
//   EOB_RUN/ZRL_RUN : run values that, with size 0, mark end-of-block / 16-zero run
//   LAST_IDX     : last zig-zag index of an 8x8 block
//   MAX_DC_SIZE / MAX_AC_SIZE : largest legal amplitude bit counts
package jpeg_pkg;

  typedef enum logic [1:0] {
    S_DC   = 2'd0,
    S_AC   = 2'd1,
    S_ZERO = 2'd2,
    S_FILL = 2'd3
  } state_t;

  localparam logic [3:0] EOB_RUN     = 4'd0;
  localparam logic [3:0] ZRL_RUN     = 4'd15;
  localparam logic [5:0] LAST_IDX    = 6'd63;
  localparam logic [3:0] MAX_DC_SIZE = 4'd11;
  localparam logic [3:0] MAX_AC_SIZE = 4'd10;

endpackage

// File: rtl/jpeg_extend.sv
// Combinational JPEG "extend": turns (size, raw amplitude bits) into a signed
// coefficient value. A set top bit means the value is the bits themselves;
// a clear top bit means value = bits - (2^size - 1).
// Ports:
//   size : amplitude bit count; 0 gives 0, counts above MAX_DC_SIZE give 0
//   amp  : raw amplitude bits, LSB-aligned
//   val  : signed result, sign-extended to WIDTH
module jpeg_extend
  import jpeg_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]              size,
  input  logic [10:0]             amp,
  output logic signed [WIDTH-1:0] val
);

  logic [11:0] mask;
  logic [11:0] mag;

  always_comb begin
    mask = '0;
    mag  = '0;
    val  = '0;
    if (size != 4'd0 && size <= MAX_DC_SIZE) begin
      mask = (12'd1 << size) - 12'd1;
      mag  = {1'b0, amp} & mask;
      if (amp[size - 4'd1]) begin
        val = WIDTH'(mag);
      end else begin
        // mag < 2^(size-1) here, so the 12-bit difference is a valid negative number.
        val = WIDTH'($signed(mag - mask));
      end
    end
  end

endmodule

// File: rtl/rle_coeff_expander.sv
// Run-length coefficient expander: converts one block's (run, size, amplitude)
// symbols into exactly 64 coefficient writes in zig-zag order 0..63, with DC
// prediction per colour component. Zeros are written explicitly; block_done
// marks the write of index 63.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high (sym_valid/sym_ready on the input, coeff_valid/out_ready on the output).
// Once coeff_valid is raised, the output registers hold until out_ready.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   restart         : zero all DC predictors (applied while in S_DC)
//   sym_*           : symbol from the Huffman decoder
//   coeff_out/index : coefficient write to the accumulator
//   coeff_valid, out_ready, block_done
//   rle_error       : sticky error flag
//   err_count       : saturating error-cycle counter (only with RLE_ERR_COUNT_EN)
//   dbg_state       : current FSM state
// Optional feature macro: RLE_ERR_COUNT_EN
module rle_coeff_expander
  import jpeg_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_COMP = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    restart,
  input  logic                    sym_valid,
  output logic                    sym_ready,
  input  logic [3:0]              sym_run,
  input  logic [3:0]              sym_size,
  input  logic [10:0]             sym_amp,
  input  logic [1:0]              sym_comp,
  output logic signed [WIDTH-1:0] coeff_out,
  output logic [5:0]              coeff_index,
  output logic                    coeff_valid,
  output logic                    block_done,
  input  logic                    out_ready,
  output logic                    rle_error,
`ifdef RLE_ERR_COUNT_EN
  output logic [7:0]              err_count,
`endif
  output state_t                  dbg_state
);

  state_t                  state, state_nx;
  logic [5:0]              idx, idx_nx;
  logic [4:0]              zcnt, zcnt_nx, zcnt_dec;
  logic signed [WIDTH-1:0] held_val, held_nx;
  logic                    pending, pend_nx;
  logic signed [WIDTH-1:0] pred    [NUM_COMP];
  logic signed [WIDTH-1:0] pred_nx [NUM_COMP];

  logic                    slot_free;
  logic                    accept;
  logic                    comp_ok;
  logic signed [WIDTH-1:0] ext_val;
  logic signed [WIDTH-1:0] dc_diff, ac_val, pred_base, pred_sum;

  logic                    emit;
  logic signed [WIDTH-1:0] emit_val;
  logic [5:0]              emit_idx;
  logic                    emit_last;
  logic                    err;

  assign slot_free = !coeff_valid || out_ready;
  assign sym_ready = !rst && slot_free && (state == S_DC || state == S_AC);
  assign accept    = sym_valid && sym_ready;
  assign comp_ok   = (int'(sym_comp) < NUM_COMP);
  assign zcnt_dec  = zcnt - 5'd1;
  assign dbg_state = state;

  jpeg_extend #(.WIDTH(WIDTH)) u_extend (
    .size (sym_size),
    .amp  (sym_amp),
    .val  (ext_val)
  );

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    zcnt_nx   = zcnt;
    held_nx   = held_val;
    pend_nx   = pending;
    for (int i = 0; i < NUM_COMP; i++) pred_nx[i] = pred[i];
    emit      = 1'b0;
    emit_val  = '0;
    err       = 1'b0;
    dc_diff   = '0;
    ac_val    = '0;
    pred_base = '0;
    pred_sum  = '0;

    case (state)
      S_DC: begin
        if (restart) begin
          for (int i = 0; i < NUM_COMP; i++) pred_nx[i] = '0;
        end
        if (accept) begin
          if (sym_size > MAX_DC_SIZE) err = 1'b1;
          else                        dc_diff = ext_val;
          if (comp_ok) begin
            // A restart in the accept cycle zeroes the predictor first.
            pred_base         = restart ? '0 : pred[sym_comp];
            pred_sum          = pred_base + dc_diff;
            pred_nx[sym_comp] = pred_sum;
          end else begin
            // Unknown component: no predictor is touched, the raw difference is emitted.
            err      = 1'b1;
            pred_sum = dc_diff;
          end
          emit     = 1'b1;
          emit_val = pred_sum;
          idx_nx   = 6'd1;
          state_nx = S_AC;
        end
      end

      S_AC: begin
        if (accept) begin
          if (sym_size > MAX_AC_SIZE) err = 1'b1;
          else                        ac_val = ext_val;
          if (sym_run == EOB_RUN && sym_size == 4'd0) begin
            state_nx = S_FILL;
          end else if (sym_run == ZRL_RUN && sym_size == 4'd0) begin
            zcnt_nx  = 5'd16;
            pend_nx  = 1'b0;
            state_nx = S_ZERO;
          end else if (sym_run == 4'd0) begin
            emit     = 1'b1;
            emit_val = ac_val;
          end else begin
            zcnt_nx  = {1'b0, sym_run};
            held_nx  = ac_val;
            pend_nx  = 1'b1;
            state_nx = S_ZERO;
          end
        end
      end

      S_ZERO: begin
        if (slot_free) begin
          emit = 1'b1;
          if (zcnt == 5'd0) begin
            // Only reachable with a held value waiting behind its run.
            emit_val = held_val;
            pend_nx  = 1'b0;
            state_nx = S_AC;
          end else begin
            emit_val = '0;
            zcnt_nx  = zcnt_dec;
            if (idx == LAST_IDX) begin
              // Block ends inside the run: anything still owed is dropped.
              if (zcnt_dec != 5'd0 || pending) err = 1'b1;
              pend_nx = 1'b0;
              zcnt_nx = 5'd0;
            end else if (zcnt_dec == 5'd0 && !pending) begin
              state_nx = S_AC;
            end
          end
        end
      end

      S_FILL: begin
        if (slot_free) begin
          emit     = 1'b1;
          emit_val = '0;
        end
      end

      default: state_nx = S_DC;
    endcase

    // Every AC-side write advances the index; the write of 63 closes the block.
    if (emit && state != S_DC) begin
      if (idx == LAST_IDX) begin
        state_nx = S_DC;
        idx_nx   = 6'd0;
      end else begin
        idx_nx = idx + 6'd1;
      end
    end
  end

  assign emit_idx  = (state == S_DC) ? 6'd0 : idx;
  assign emit_last = (state != S_DC) && (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_DC;
      idx         <= '0;
      zcnt        <= '0;
      held_val    <= '0;
      pending     <= 1'b0;
      for (int i = 0; i < NUM_COMP; i++) pred[i] <= '0;
      coeff_out   <= '0;
      coeff_index <= '0;
      coeff_valid <= 1'b0;
      block_done  <= 1'b0;
      rle_error   <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      zcnt     <= zcnt_nx;
      held_val <= held_nx;
      pending  <= pend_nx;
      for (int i = 0; i < NUM_COMP; i++) pred[i] <= pred_nx[i];
      if (emit) begin
        coeff_valid <= 1'b1;
        coeff_out   <= emit_val;
        coeff_index <= emit_idx;
        block_done  <= emit_last;
      end else if (out_ready) begin
        coeff_valid <= 1'b0;
        block_done  <= 1'b0;
      end
      if (err) rle_error <= 1'b1;
    end
  end

`ifdef RLE_ERR_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (err && err_count != 8'hFF) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_coeff_expander.sv
// Testbench for rle_coeff_expander: directed symbol streams, expected writes
// queued as {block_done, index, value}, compared by an output monitor.
module tb_rle_coeff_expander;
  import jpeg_pkg::*;

  localparam int WIDTH    = 16;
  localparam int NUM_COMP = 3;
  localparam int EW       = WIDTH + 7;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    restart = 1'b0;
  logic                    sym_valid = 1'b0;
  logic                    sym_ready;
  logic [3:0]              sym_run = '0;
  logic [3:0]              sym_size = '0;
  logic [10:0]             sym_amp = '0;
  logic [1:0]              sym_comp = '0;
  logic signed [WIDTH-1:0] coeff_out;
  logic [5:0]              coeff_index;
  logic                    coeff_valid;
  logic                    block_done;
  logic                    out_ready = 1'b1;
  logic                    rle_error;
  state_t                  dbg_state;
`ifdef RLE_ERR_COUNT_EN
  logic [7:0]              err_count;
`endif

  rle_coeff_expander #(.WIDTH(WIDTH), .NUM_COMP(NUM_COMP)) dut (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_run     (sym_run),
    .sym_size    (sym_size),
    .sym_amp     (sym_amp),
    .sym_comp    (sym_comp),
    .coeff_out   (coeff_out),
    .coeff_index (coeff_index),
    .coeff_valid (coeff_valid),
    .block_done  (block_done),
    .out_ready   (out_ready),
    .rle_error   (rle_error),
`ifdef RLE_ERR_COUNT_EN
    .err_count   (err_count),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0]           exp_q[$];
  logic signed [WIDTH-1:0] blk [64];
  int                      total = 0;
  int                      bad = 0;
  int                      xfer_cnt = 0;
  logic                    toggle_en = 1'b0;
  logic                    stall_q = 1'b0;
  logic [EW:0]             held_q = '0;
  logic [EW-1:0]           e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_blk();
    for (int i = 0; i < 64; i++) blk[i] = '0;
  endtask

  task automatic push_blk();
    for (int i = 0; i < 64; i++) begin
      logic [5:0] ix;
      ix = 6'(i);
      exp_q.push_back({(i == 63), ix, blk[i]});
    end
  endtask

  // Output monitor: checks every transfer against the queue and that stalled
  // outputs stay unchanged until accepted.
  always @(negedge clk) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        total++;
        if ({coeff_valid, block_done, coeff_index, coeff_out} !== held_q) begin
          bad++;
          $display("FAIL hold: got %h expected %h", {coeff_valid, block_done, coeff_index, coeff_out}, held_q);
        end
      end
      if (coeff_valid && out_ready) begin
        xfer_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected write: done=%0b idx=%0d val=%0d", block_done, coeff_index, coeff_out);
        end else begin
          e = exp_q.pop_front();
          if ({block_done, coeff_index, coeff_out} !== e) begin
            bad++;
            $display("FAIL coeff: got done=%0b idx=%0d val=%0d expected done=%0b idx=%0d val=%0d",
                     block_done, coeff_index, coeff_out, e[EW-1], e[EW-2:WIDTH], $signed(e[WIDTH-1:0]));
          end
        end
      end
      stall_q = coeff_valid && !out_ready;
      held_q  = {coeff_valid, block_done, coeff_index, coeff_out};
    end
  end

  always @(posedge clk) begin
    if (toggle_en) begin
      #1 out_ready = ~out_ready;
    end
  end

  // ---------------- drivers ----------------
  task automatic send(input logic [3:0] run, input logic [3:0] size, input logic [10:0] amp,
                      input logic [1:0] comp, input logic rs);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    sym_valid = 1'b1;
    sym_run   = run;
    sym_size  = size;
    sym_amp   = amp;
    sym_comp  = comp;
    restart   = rs;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sym_ready) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    sym_valid = 1'b0;
    restart   = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send: symbol run=%0d size=%0d not accepted, got ready=0 expected 1", run, size);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !coeff_valid) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: %0d writes outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- stimulus ----------------
  int  x0;
  bit  found;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(coeff_valid), 0);
    check("rst_done", 32'(block_done), 0);
    check("rst_index", 32'(coeff_index), 0);
    check("rst_coeff", 32'(coeff_out), 0);
    check("rst_err", 32'(rle_error), 0);
    check("rst_ready", 32'(sym_ready), 0);
    check("rst_state", 32'(dbg_state), 32'(S_DC));
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 32'(sym_ready), 1);

    // T1: DC +5 on comp0 then EOB
    clr_blk(); blk[0] = 16'sd5; push_blk();
    x0 = xfer_cnt;
    send(4'd0, 4'd3, 11'b101, 2'd0, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    drain();
    check("t1_xfers", 32'(xfer_cnt - x0), 64);
    check("t1_err", 32'(rle_error), 0);

    // T2: DC diff -2 -> 3; then restart with DC +1 -> 1
    clr_blk(); blk[0] = 16'sd3; push_blk();
    send(4'd0, 4'd2, 11'b01, 2'd0, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    clr_blk(); blk[0] = 16'sd1; push_blk();
    send(4'd0, 4'd1, 11'b1, 2'd0, 1'b1);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    drain();

    // T3: comp1 DC 0, AC run2 size2 amp 11 -> idx3 = +3
    clr_blk(); blk[3] = 16'sd3; push_blk();
    send(4'd0, 4'd0, 11'd0, 2'd1, 1'b0);
    send(4'd2, 4'd2, 11'b11, 2'd1, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    drain();
    check("t3_err", 32'(rle_error), 0);

    // T4a: comp2 DC 0, ZRL x3, run15 size1 -> run crosses 63, value dropped
    clr_blk(); push_blk();
    send(4'd0, 4'd0, 11'd0, 2'd2, 1'b0);
    repeat (3) send(ZRL_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    send(4'd15, 4'd1, 11'd1, 2'd0, 1'b0);
    drain();
    check("t4a_err", 32'(rle_error), 1);
    check("t4a_state", 32'(dbg_state), 32'(S_DC));

    // T4b: ZRL x3, run14 size1 amp0 -> idx63 = -1, natural end; next is DC (comp0 1+1=2)
    clr_blk(); blk[63] = -16'sd1; push_blk();
    send(4'd0, 4'd0, 11'd0, 2'd2, 1'b0);
    repeat (3) send(ZRL_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    send(4'd14, 4'd1, 11'd0, 2'd0, 1'b0);
    clr_blk(); blk[0] = 16'sd2; push_blk();
    send(4'd0, 4'd1, 11'd1, 2'd0, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    drain();

    // T5: out_ready toggling; comp1 DC -8, idx1 +4, idx3 -1
    clr_blk(); blk[0] = -16'sd8; blk[1] = 16'sd4; blk[3] = -16'sd1; push_blk();
    x0 = xfer_cnt;
    toggle_en = 1'b1;
    send(4'd0, 4'd4, 11'b0111, 2'd1, 1'b0);
    send(4'd0, 4'd3, 11'b100, 2'd0, 1'b0);
    send(4'd1, 4'd1, 11'd0, 2'd0, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    drain();
    @(posedge clk); toggle_en = 1'b0;
    #2 out_ready = 1'b1;
    check("t5_xfers", 32'(xfer_cnt - x0), 64);

    // T6: reset at idx 20 abandons the block; predictors restart at 0
    clr_blk(); blk[0] = 16'sd3; push_blk();
    send(4'd0, 4'd1, 11'd1, 2'd0, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (coeff_valid && coeff_index == 6'd20) found = 1'b1;
    end
    check("t6_reach20", 32'(found), 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t6_valid", 32'(coeff_valid), 0);
    check("t6_done", 32'(block_done), 0);
    check("t6_err", 32'(rle_error), 0);
    clr_blk(); push_blk();
    send(4'd0, 4'd0, 11'd0, 2'd0, 1'b0);
    send(EOB_RUN, 4'd0, 11'd0, 2'd0, 1'b0);
    drain();
    repeat (5) @(negedge clk);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
